// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module  : systolic_feeder
// Purpose : Buffers A rows / B columns and streams them skewed into an NxN array.
// Revision: 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int ARR_SIZE      = 4,
  parameter int HORIZONTAL_BW = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic                               wr_sel,
  input  logic [$clog2(ARR_SIZE)-1:0]        wr_idx,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0]  wr_data,
  input  logic                               start,
  input  logic                               mode_in,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0]  h_out,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0]  v_out,
  output logic                               mode_out,
  output logic                               busy,
  output logic                               done,
  output logic                               start_err
);

  localparam int N  = ARR_SIZE;
  localparam int W  = HORIZONTAL_BW;
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2 * N);
  localparam logic [TW-1:0] c_STREAM_LAST = TW'(2 * N - 2);
  localparam logic [TW-1:0] c_DRAIN_LAST  = TW'(2 * N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_t;
  logic [TW-1:0]       w_t_nxt;
  logic [W*N-1:0]      r_a [N];
  logic [W*N-1:0]      r_b [N];
  logic [W*N-1:0]      w_a_eff [N];
  logic [W*N-1:0]      w_b_eff [N];
  logic [N-1:0]        r_a_ld;
  logic [N-1:0]        r_b_ld;
  logic [W*N-1:0]      r_h;
  logic [W*N-1:0]      r_v;
  logic [W*N-1:0]      w_h_nxt;
  logic [W*N-1:0]      w_v_nxt;
  logic                r_mode;
  logic                r_start_err;
  logic                w_wr_acc;
  logic                w_accept;
  logic                w_reject;
  logic                w_clr_flags;
  logic                w_all_loaded;

  assign wr_ready     = (r_state == S_IDLE);
  assign w_wr_acc     = wr_valid && wr_ready;
  assign w_all_loaded = (&r_a_ld) && (&r_b_ld);

  assign h_out     = r_h;
  assign v_out     = r_v;
  assign mode_out  = r_mode;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DRAIN) && (r_t == c_DRAIN_LAST);
  assign start_err = r_start_err;

  // Write forwarding so a write landing on the start-accept edge is streamed at t=0.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_eff[i] = r_a[i];
      w_b_eff[i] = r_b[i];
      if (w_wr_acc && !wr_sel && (wr_idx == IW'(i))) w_a_eff[i] = wr_data;
      if (w_wr_acc &&  wr_sel && (wr_idx == IW'(i))) w_b_eff[i] = wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_clr_flags = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_all_loaded) begin
            w_state_nxt = S_STREAM;
            w_t_nxt     = '0;
            w_accept    = 1'b1;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (r_t == c_STREAM_LAST) begin
          w_state_nxt = S_DRAIN;
          w_t_nxt     = '0;
        end else begin
          w_t_nxt     = r_t + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_t == c_DRAIN_LAST) begin
          w_state_nxt = S_IDLE;
          w_t_nxt     = '0;
          w_clr_flags = 1'b1;
        end else begin
          w_t_nxt     = r_t + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_t_nxt     = '0;
      end
    endcase
  end

  // Lane i of h carries A[i][t-i]; lane j of v carries B[t-j][j].
  always_comb begin
    w_h_nxt = '0;
    w_v_nxt = '0;
    if (w_state_nxt == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if ((i + k) == int'(w_t_nxt)) begin
            w_h_nxt[i*W +: W] = w_a_eff[i][k*W +: W];
            w_v_nxt[i*W +: W] = w_b_eff[i][k*W +: W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_h         <= '0;
      r_v         <= '0;
      r_mode      <= 1'b0;
      r_start_err <= 1'b0;
      r_a_ld      <= '0;
      r_b_ld      <= '0;
      for (int i = 0; i < N; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_t         <= w_t_nxt;
      r_h         <= w_h_nxt;
      r_v         <= w_v_nxt;
      r_start_err <= w_reject;
      if (w_accept) r_mode <= mode_in;
      for (int i = 0; i < N; i++) begin
        r_a[i] <= w_a_eff[i];
        r_b[i] <= w_b_eff[i];
      end
      if (w_clr_flags) begin
        r_a_ld <= '0;
        r_b_ld <= '0;
      end else if (w_wr_acc) begin
        if (wr_sel) r_b_ld[wr_idx] <= 1'b1;
        else        r_a_ld[wr_idx] <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
